// File: rtl/player_defs.sv
// rtl/player_defs.sv - shared opcodes, directions, field slices and player FSM encoding
package player_defs;

  localparam logic [3:0] HPY = 4'd1;
  localparam logic [3:0] DPY = 4'd2;
  localparam logic [3:0] IDG = 4'd3;
  localparam logic [3:0] SDG = 4'd4;
  localparam logic [3:0] MOV = 4'd5;
  localparam logic [3:0] SHP = 4'd6;

  localparam logic [7:0] UP    = 8'd0;
  localparam logic [7:0] LEFT  = 8'd1;
  localparam logic [7:0] DOWN  = 8'd2;
  localparam logic [7:0] RIGHT = 8'd3;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int ARG_HI = 11;
  localparam int ARG_LO = 4;

  typedef enum logic [1:0] {ALIVE = 2'd0, HIT = 2'd1, DEAD = 2'd2} pstate_t;

  // One step along an axis, clamped to [lo, hi]; 11-bit math so a step below 0 cannot wrap.
  function automatic logic [9:0] clamp_step(input logic [9:0] pos, input logic neg,
                                             input logic [9:0] lo, input logic [9:0] hi,
                                             input logic [9:0] step);
    logic [10:0] s;
    logic [9:0]  r;
    if (neg) begin
      if ({1'b0, pos} < ({1'b0, lo} + {1'b0, step})) r = lo;
      else r = pos - step;
    end else begin
      s = {1'b0, pos} + {1'b0, step};
      if (s > {1'b0, hi}) r = hi;
      else r = s[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/player_move_tick.sv
// rtl/player_move_tick.sv - MOVE_DIV prescaler emitting a one-cycle move tick
module player_move_tick #(
  parameter int MOVE_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/player_executor.sv
// rtl/player_executor.sv - executes MOV/HPY/DPY/SHP on player position and HP
module player_executor
  import player_defs::*;
#(
  parameter int         HP_MAX   = 100,
  parameter logic [9:0] X_MIN    = 10'd200,
  parameter logic [9:0] X_MAX    = 10'd440,
  parameter logic [9:0] Y_MIN    = 10'd240,
  parameter logic [9:0] Y_MAX    = 10'd400,
  parameter int         STEP     = 4,
  parameter int         MOVE_DIV = 250000,
  parameter int         IFRAME   = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        is_move,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic [7:0]  player_hp,
  output logic        is_death,
  output logic        invuln,
  output logic        hp_ack
);

  localparam int IW = (IFRAME > 1) ? $clog2(IFRAME) : 1;
  localparam logic [9:0] X_MID = 10'((int'(X_MIN) + int'(X_MAX)) / 2);
  localparam logic [9:0] Y_MID = 10'((int'(Y_MIN) + int'(Y_MAX)) / 2);
  localparam logic [7:0] HPM   = 8'(HP_MAX);
  localparam logic [9:0] STP   = 10'(STEP);

  pstate_t       state, state_n;
  logic [15:0]   prev_instr;
  logic [IW-1:0] ifc, ifc_n;
  logic [9:0]    x_n, y_n;
  logic [7:0]    hp_n;
  logic          ack_n;
  logic          tick;

  logic [3:0] opcode;
  logic [7:0] arg;
  logic       hp_edge;
  logic [8:0] heal_sum;
  logic [7:0] heal_v, dmg_v, set_v;

  player_move_tick #(.MOVE_DIV(MOVE_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign opcode   = instr[OP_HI:OP_LO];
  assign arg      = instr[ARG_HI:ARG_LO];
  // HP ops are level-held upstream, so they fire only when the word changes.
  assign hp_edge  = (instr != prev_instr);
  assign heal_sum = {1'b0, player_hp} + {1'b0, arg};
  assign heal_v   = (heal_sum > {1'b0, HPM}) ? HPM : heal_sum[7:0];
  assign dmg_v    = (arg >= player_hp) ? 8'd0 : (player_hp - arg);
  assign set_v    = (arg > HPM) ? HPM : arg;

  assign is_death = (state == DEAD);
  assign invuln   = (state == HIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ALIVE;
      prev_instr <= 16'h0000;
      ifc        <= '0;
      player_x   <= X_MID;
      player_y   <= Y_MID;
      player_hp  <= HPM;
      hp_ack     <= 1'b0;
    end else begin
      state      <= state_n;
      prev_instr <= instr;
      ifc        <= ifc_n;
      player_x   <= x_n;
      player_y   <= y_n;
      player_hp  <= hp_n;
      hp_ack     <= ack_n;
    end
  end

  always_comb begin
    state_n = state;
    ifc_n   = ifc;
    x_n     = player_x;
    y_n     = player_y;
    hp_n    = player_hp;
    ack_n   = 1'b0;

    if (state == HIT) begin
      if (ifc == '0) state_n = ALIVE;
      else           ifc_n   = ifc - IW'(1);
    end

    case (opcode)
      HPY: begin
        if (hp_edge && state != DEAD) begin
          hp_n  = heal_v;
          ack_n = 1'b1;
        end
      end
      DPY: begin
        if (hp_edge && state == ALIVE) begin
          hp_n  = dmg_v;
          ack_n = 1'b1;
          if (dmg_v == 8'd0) begin
            state_n = DEAD;
          end else begin
            state_n = HIT;
            ifc_n   = IW'(IFRAME - 1);
          end
        end
      end
      SHP: begin
        if (hp_edge) begin
          hp_n  = set_v;
          ack_n = 1'b1;
          // Setting HP to zero kills from any state; a nonzero set revives from DEAD.
          if (set_v == 8'd0)       state_n = DEAD;
          else if (state == DEAD)  state_n = ALIVE;
        end
      end
      MOV: begin
        if (tick && is_move && state != DEAD) begin
          case (arg)
            UP:      y_n = clamp_step(player_y, 1'b1, Y_MIN, Y_MAX, STP);
            LEFT:    x_n = clamp_step(player_x, 1'b1, X_MIN, X_MAX, STP);
            DOWN:    y_n = clamp_step(player_y, 1'b0, Y_MIN, Y_MAX, STP);
            RIGHT:   x_n = clamp_step(player_x, 1'b0, X_MIN, X_MAX, STP);
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule
